// File: rtl/div_iter_pkg.sv
`timescale 1ns/1ps
// Shared types for the iterative divider.
package div_iter_pkg;

  // Operation sequencing: accept in idle, one restoring step per cycle in busy, then one
  // result cycle that raises the valid pulse.
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESULT
  } div_iter_state_t;

endpackage

// File: rtl/div_step.sv
`timescale 1ns/1ps
// div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor;
// the sign of the (W+1)-bit difference decides whether the subtraction is kept.
//   rem      in   W  current partial remainder (always < dsr when dsr != 0)
//   q_msb    in   1  dividend bit being shifted in
//   dsr      in   W  divisor
//   rem_nxt  out  W  partial remainder after this step
//   q_bit    out  1  quotient bit produced by this step
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         q_msb,
  input  logic [W-1:0] dsr,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);

  logic [W:0] t;
  logic [W:0] d;

  always_comb begin
    t       = {rem, q_msb};
    d       = t - {1'b0, dsr};
    // A borrow out of the top bit means the divisor did not fit: restore.
    q_bit   = ~d[W];
    rem_nxt = d[W] ? t[W-1:0] : d[W-1:0];
  end

endmodule

// File: rtl/div_iter.sv
`timescale 1ns/1ps
// div_iter: multi-cycle radix-2 restoring unsigned divider, W iterations per operation.
// Shares the pass / busy_r / y_vld_r handshake of the iterative multiplier so the two
// datapaths are interchangeable behind the same control logic.
//   clk      in   1  clock
//   rst      in   1  synchronous active-high reset
//   a        in   W  dividend, sampled on an accepted pass
//   b        in   W  divisor, sampled on an accepted pass
//   pass     in   1  start; accepted only while busy_r is low
//   q        out  W  quotient register
//   r        out  W  remainder register
//   y_vld_r  out  1  one-cycle pulse: q and r hold the finished result
//   dbz_r    out  1  last accepted operation had b == 0; held until next accept
//   busy_r   out  1  operation in flight; pass ignored
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         pass,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         y_vld_r,
  output logic         dbz_r,
  output logic         busy_r
);

  localparam int unsigned CntW = $clog2(W);

  div_iter_state_t state_q;
  logic [W-1:0]    q_reg;
  logic [W-1:0]    rem_q;
  logic [W-1:0]    dsr_q;
  logic [CntW-1:0] cnt_q;

  logic [W-1:0]    rem_nxt;
  logic            q_bit;

  // q_reg doubles as the dividend shift register: its MSB feeds the remainder while
  // quotient bits enter at the LSB, so after W steps it holds the full quotient.
  div_step #(
    .W(W)
  ) u_step (
    .rem    (rem_q),
    .q_msb  (q_reg[W-1]),
    .dsr    (dsr_q),
    .rem_nxt(rem_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_reg   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      y_vld_r <= 1'b0;
      dbz_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      y_vld_r <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pass) begin
            q_reg   <= a;
            rem_q   <= '0;
            dsr_q   <= b;
            dbz_r   <= (b == '0);
            cnt_q   <= CntW'(W - 1);
            busy_r  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          rem_q <= rem_nxt;
          q_reg <= {q_reg[W-2:0], q_bit};
          if (cnt_q == '0) begin
            state_q <= S_RESULT;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        S_RESULT: begin
          y_vld_r <= 1'b1;
          busy_r  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign q = q_reg;
  assign r = rem_q;

endmodule

// File: tb/tb_div_iter.sv
`timescale 1ns/1ps
// Scoreboard bench for div_iter: a 32-bit instance for directed cases and an 8-bit
// instance for an operand sweep against a reference model.
module tb_div_iter;

  localparam int unsigned W32 = 32;
  localparam int unsigned W8  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W32-1:0] a32, b32, q32, r32;
  logic           pass32, vld32, dbz32, busy32;
  logic [W8-1:0]  a8, b8, q8, r8;
  logic           pass8, vld8, dbz8, busy8;

  div_iter #(.W(W32)) u_dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .pass(pass32),
    .q(q32), .r(r32), .y_vld_r(vld32), .dbz_r(dbz32), .busy_r(busy32)
  );

  div_iter #(.W(W8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .pass(pass8),
    .q(q8), .r(r8), .y_vld_r(vld8), .dbz_r(dbz8), .busy_r(busy8)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int unsigned t0;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t e32, e8;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare whenever a valid pulse appears.
  always @(negedge clk) begin
    if (!rst && vld32) begin
      if (sb32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w32_spurious_vld: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e32 = sb32.pop_front();
        check("w32_q", q32, e32.q);
        check("w32_r", r32, e32.r);
        check("w32_dbz", {31'b0, dbz32}, {31'b0, e32.dbz});
        check("w32_busy_at_vld", {31'b0, busy32}, 32'd0);
        check("w32_latency", cyc - e32.t0, W32 + 2);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vld8) begin
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_spurious_vld: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e8 = sb8.pop_front();
        check("w8_q", {24'b0, q8}, e8.q);
        check("w8_r", {24'b0, r8}, e8.r);
        check("w8_dbz", {31'b0, dbz8}, {31'b0, e8.dbz});
        check("w8_latency", cyc - e8.t0, W8 + 2);
      end
    end
  end

  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int n;
    n = 0;
    @(negedge clk);
    while (busy32 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy32) begin
      checks++;
      errors++;
      $display("FAIL w32_busy_timeout: got busy expected idle");
    end else begin
      a32    = a;
      b32    = b;
      pass32 = 1'b1;
      sb32.push_back('{eq, er, edbz, cyc});
      @(posedge clk);
      #1 pass32 = 1'b0;
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    int n;
    logic [31:0] eq, er;
    n = 0;
    if (b == 8'd0) begin
      eq = 32'hFF;
      er = {24'b0, a};
    end else begin
      eq = {24'b0, a / b};
      er = {24'b0, a % b};
    end
    @(negedge clk);
    while (busy8 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (busy8) begin
      checks++;
      errors++;
      $display("FAIL w8_busy_timeout: got busy expected idle");
    end else begin
      a8    = a;
      b8    = b;
      pass8 = 1'b1;
      sb8.push_back('{eq, er, (b == 8'd0), cyc});
      @(posedge clk);
      #1 pass8 = 1'b0;
    end
  endtask

  logic [7:0] edge_v [7];

  initial begin
    int n;
    edge_v = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};
    rst    = 1'b1;
    a32    = '0;
    b32    = '0;
    pass32 = 1'b0;
    a8     = '0;
    b8     = '0;
    pass8  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_q", q32, 32'd0);
    check("rst_r", r32, 32'd0);
    check("rst_flags", {29'b0, vld32, dbz32, busy32}, 32'd0);
    check("rst_w8_flags", {29'b0, vld8, dbz8, busy8}, 32'd0);
    rst = 1'b0;

    // Directed W=32 cases; each waits only for busy_r low, so these run back-to-back.
    issue32(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    issue32(32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
    issue32(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue32(32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    issue32(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    issue32(32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0);
    issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    issue32(32'h80000000, 32'h00010000, 32'h00008000, 32'd0, 1'b0);
    issue32(32'd1000, 32'd999, 32'd1, 32'd1, 1'b0);

    // Pass while busy must be ignored.
    issue32(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (4) @(negedge clk);
    a32    = 32'd50;
    b32    = 32'd5;
    pass32 = 1'b1;
    @(negedge clk);
    pass32 = 1'b0;
    check("ignored_pass_busy", {31'b0, busy32}, 32'd1);

    // Reset mid-operation aborts without a valid pulse.
    issue32(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy32}, 32'd0);
    check("abort_q", q32, 32'd0);
    check("abort_r", r32, 32'd0);
    check("abort_vld", {31'b0, vld32}, 32'd0);
    void'(sb32.pop_back());
    rst = 1'b0;
    issue32(32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

    // W=8 sweep: all edge-value pairs, then random pairs.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        issue8(edge_v[i], edge_v[j]);
      end
    end
    for (int k = 0; k < 1500; k++) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    n = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("w32_drain", sb32.size(), 32'd0);
    check("w8_drain", sb8.size(), 32'd0);
    // Idle window to catch any late or duplicate pulses.
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
